// File: rtl/calc_control_unit_n.sv
// Calculator control unit: keypad strobes -> signed N-digit operands,
// left-to-right operator chaining and a multi-cycle mul/div sequencer.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-low
//   button          key code (0-9 digit, A add/div, B sub/dec,
//                   C mul/neg, D toggle, E equal, F clear)
//   is_pressed_next one-cycle strobe qualifying button
//   display_value   signed value to show
//   entering_b      operand B is being shown/entered
//   op_code         pending operator (0 add, 1 sub, 2 mul, 3 div)
//   toggle_active   secondary-function latch
//   busy            multi-cycle arithmetic in progress
//   done            one-cycle pulse on entry to RESULT
//   error           0 none, 1 overflow, 2 divide-by-zero (sticky)
module calc_control_unit_n #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              button,
    input  logic                    is_pressed_next,
    output logic signed [WIDTH-1:0] display_value,
    output logic                    entering_b,
    output logic [1:0]              op_code,
    output logic                    toggle_active,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              error
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_MUL = 4'hC;
    localparam logic [3:0] K_TOG = 4'hD;
    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_CLR = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] POS_LIM = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] NEG_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_EXECUTE,
        S_RESULT,
        S_ERROR
    } state_t;

    state_t state;

    logic signed [W-1:0] a, b, res;
    logic [CW-1:0]       cnt_a, cnt_b;
    logic [1:0]          next_op;
    logic                chain;
    logic                neg_r;
    logic [SW-1:0]       stp;
    logic [2*W-1:0]      ma, acc;
    logic [W-1:0]        mb, dq;

    function automatic logic [W-1:0] mag_of(input logic signed [W-1:0] v);
        mag_of = v[W-1] ? (~v + 1'b1) : v;
    endfunction

    logic k_digit, k_clr, k_tog, k_eq, k_opkey, op_sel, neg_key;
    logic [1:0] key_op;
    logic in_b;
    logic signed [W-1:0] opnd, x10, dval, dig_val, neg_src, neg_val;
    logic signed [W-1:0] ex_x;
    logic [CW-1:0] ocnt, dig_cnt;
    logic neg_ovf;
    logic signed [W:0] sx, sb, sum;
    logic as_ovf;
    logic exec_key, start_md;
    logic [2*W-1:0] acc_mul, mag;
    logic [W:0] rem_sh, rem_n;
    logic ge;
    logic [W-1:0] dq_n;
    logic md_ovf;
    logic signed [W-1:0] md_val;
    logic last;
    logic fin_go, fin_ovf, fin_chain;
    logic signed [W-1:0] fin_val;
    logic [1:0] fin_op;

    always_comb begin
        k_digit = is_pressed_next && (button <= 4'd9);
        k_clr   = is_pressed_next && (button == K_CLR);
        k_tog   = is_pressed_next && (button == K_TOG);
        k_eq    = is_pressed_next && (button == K_EQ);
        k_opkey = is_pressed_next &&
                  (button == K_ADD || button == K_SUB || button == K_MUL);
        neg_key = k_opkey && button == K_MUL && toggle_active;
        op_sel  = k_opkey && (button == K_ADD || !toggle_active);

        key_op = OP_ADD;
        case (button)
            K_ADD:   key_op = toggle_active ? OP_DIV : OP_ADD;
            K_SUB:   key_op = OP_SUB;
            K_MUL:   key_op = OP_MUL;
            default: key_op = OP_ADD;
        endcase

        // Digit entry on the operand currently being typed
        in_b    = (state == S_ENTER_B);
        opnd    = in_b ? b : a;
        ocnt    = in_b ? cnt_b : cnt_a;
        x10     = (opnd <<< 3) + (opnd <<< 1);
        dval    = {{(W-4){1'b0}}, button};
        dig_val = opnd[W-1] ? (x10 - dval) : (x10 + dval);
        // Leading zeros leave the count untouched
        dig_cnt = (opnd == '0 && button == 4'd0) ? ocnt : ocnt + 1'b1;

        neg_src = (state == S_RESULT) ? res : opnd;
        neg_val = -neg_src;
        neg_ovf = (neg_src == SMIN);

        // Left operand: result when repeating from RESULT
        ex_x   = (state == S_RESULT) ? res : a;
        sx     = {ex_x[W-1], ex_x};
        sb     = {b[W-1], b};
        sum    = (op_code == OP_SUB) ? (sx - sb) : (sx + sb);
        as_ovf = sum[W] ^ sum[W-1];

        exec_key = (state == S_ENTER_B && (k_eq || (op_sel && cnt_b != '0))) ||
                   (state == S_RESULT && k_eq);
        start_md = exec_key && op_code[1];

        // One shift-add multiply step
        acc_mul = acc + (mb[0] ? ma : '0);
        // One restoring divide step; acc holds the partial remainder
        rem_sh = {acc[W-1:0], dq[W-1]};
        ge     = (rem_sh >= {1'b0, mb});
        rem_n  = ge ? (rem_sh - {1'b0, mb}) : rem_sh;
        dq_n   = {dq[W-2:0], ge};

        mag    = (op_code == OP_DIV) ? {{W{1'b0}}, dq_n} : acc_mul;
        md_ovf = neg_r ? (mag > NEG_LIM) : (mag > POS_LIM);
        md_val = neg_r ? (~mag[W-1:0] + 1'b1) : mag[W-1:0];
        last   = (stp == SW'(W - 1));

        if (state == S_EXECUTE) begin
            fin_go    = last;
            fin_val   = md_val;
            fin_ovf   = md_ovf;
            fin_chain = chain;
            fin_op    = next_op;
        end else begin
            fin_go    = exec_key && !op_code[1];
            fin_val   = sum[W-1:0];
            fin_ovf   = as_ovf;
            fin_chain = op_sel;
            fin_op    = key_op;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_ENTER_A;
            a             <= '0;
            b             <= '0;
            res           <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            next_op       <= OP_ADD;
            chain         <= 1'b0;
            neg_r         <= 1'b0;
            stp           <= '0;
            ma            <= '0;
            mb            <= '0;
            acc           <= '0;
            dq            <= '0;
            display_value <= '0;
            entering_b    <= 1'b0;
            op_code       <= OP_ADD;
            toggle_active <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 2'd0;
        end else begin
            done <= 1'b0;
            if (k_clr) begin
                state         <= S_ENTER_A;
                a             <= '0;
                b             <= '0;
                res           <= '0;
                cnt_a         <= '0;
                cnt_b         <= '0;
                next_op       <= OP_ADD;
                chain         <= 1'b0;
                op_code       <= OP_ADD;
                toggle_active <= 1'b0;
                error         <= 2'd0;
                display_value <= '0;
                entering_b    <= 1'b0;
                busy          <= 1'b0;
            end else begin
                unique case (state)
                    S_EXECUTE: begin
                        stp <= stp + 1'b1;
                        if (op_code == OP_DIV) begin
                            acc <= {{(W-1){1'b0}}, rem_n};
                            dq  <= dq_n;
                            if (stp == '0 && mb == '0) begin
                                state         <= S_ERROR;
                                error         <= 2'd2;
                                display_value <= '0;
                                entering_b    <= 1'b0;
                                busy          <= 1'b0;
                            end
                        end else begin
                            acc <= acc_mul;
                            ma  <= ma << 1;
                            mb  <= mb >> 1;
                        end
                    end
                    S_ERROR: begin
                    end
                    default: begin
                        if (k_digit) begin
                            if (state == S_RESULT) begin
                                a             <= dval;
                                cnt_a         <= (button != 4'd0) ? CW'(1) : '0;
                                state         <= S_ENTER_A;
                                display_value <= dval;
                                entering_b    <= 1'b0;
                            end else if (ocnt < CW'(MAX_DIGITS)) begin
                                if (in_b) begin
                                    b     <= dig_val;
                                    cnt_b <= dig_cnt;
                                end else begin
                                    a     <= dig_val;
                                    cnt_a <= dig_cnt;
                                end
                                display_value <= dig_val;
                            end
                        end else if (k_tog) begin
                            toggle_active <= ~toggle_active;
                        end else if (k_opkey) begin
                            toggle_active <= 1'b0;
                            if (neg_key) begin
                                if (neg_ovf) begin
                                    state         <= S_ERROR;
                                    error         <= 2'd1;
                                    display_value <= '0;
                                    entering_b    <= 1'b0;
                                end else begin
                                    case (state)
                                        S_ENTER_A: a   <= neg_val;
                                        S_ENTER_B: b   <= neg_val;
                                        default:   res <= neg_val;
                                    endcase
                                    display_value <= neg_val;
                                end
                            end else if (op_sel) begin
                                case (state)
                                    S_ENTER_B: begin
                                        if (cnt_b == '0) op_code <= key_op;
                                    end
                                    default: begin
                                        if (state == S_RESULT) a <= res;
                                        op_code       <= key_op;
                                        b             <= '0;
                                        cnt_b         <= '0;
                                        state         <= S_ENTER_B;
                                        entering_b    <= 1'b1;
                                        display_value <= '0;
                                    end
                                endcase
                            end
                        end
                    end
                endcase

                if (start_md) begin
                    state   <= S_EXECUTE;
                    busy    <= 1'b1;
                    stp     <= '0;
                    chain   <= op_sel;
                    next_op <= key_op;
                    a       <= ex_x;
                    ma      <= {{W{1'b0}}, mag_of(ex_x)};
                    mb      <= mag_of(b);
                    acc     <= '0;
                    dq      <= mag_of(ex_x);
                    neg_r   <= ex_x[W-1] ^ b[W-1];
                end

                if (fin_go) begin
                    busy <= 1'b0;
                    if (fin_ovf) begin
                        state         <= S_ERROR;
                        error         <= 2'd1;
                        display_value <= '0;
                        entering_b    <= 1'b0;
                    end else if (fin_chain) begin
                        // Chained operator: result feeds the next operation
                        a             <= fin_val;
                        op_code       <= fin_op;
                        b             <= '0;
                        cnt_b         <= '0;
                        state         <= S_ENTER_B;
                        entering_b    <= 1'b1;
                        display_value <= fin_val;
                    end else begin
                        res           <= fin_val;
                        state         <= S_RESULT;
                        done          <= 1'b1;
                        entering_b    <= 1'b0;
                        display_value <= fin_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_control_unit_n.sv
// Bench for calc_control_unit_n: integer-level calculator model compared
// every cycle, plus hand-computed expectations on key sequences.
module tb_calc_control_unit_n;

    localparam int W  = 16;
    localparam int MD = 4;
    localparam longint LO = -(longint'(1) << (W - 1));
    localparam longint HI = (longint'(1) << (W - 1)) - 1;

    localparam int EA = 0, EB = 1, EX = 2, RS = 3, ER = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [3:0] button = 4'd0;
    logic is_pressed_next = 1'b0;
    logic signed [W-1:0] display_value;
    logic entering_b;
    logic [1:0] op_code;
    logic toggle_active, busy, done;
    logic [1:0] error;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    calc_control_unit_n #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
        .clock(clock),
        .reset(reset),
        .button(button),
        .is_pressed_next(is_pressed_next),
        .display_value(display_value),
        .entering_b(entering_b),
        .op_code(op_code),
        .toggle_active(toggle_active),
        .busy(busy),
        .done(done),
        .error(error)
    );

    task automatic cmp(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ms, ma, mb, mres, mca, mcb, mop, mtog, merr, mdisp;
    int mbusy, mdone, mentb, mcd, mfirst, mchain, mnext;
    longint mpend;

    task automatic m_reset();
        ms = EA; ma = 0; mb = 0; mres = 0; mca = 0; mcb = 0; mop = 0;
        mtog = 0; merr = 0; mdisp = 0; mbusy = 0; mdone = 0; mentb = 0;
        mcd = 0; mfirst = 0; mchain = 0; mnext = 0; mpend = 0;
    endtask

    task automatic m_finish(input longint v, input int ch, input int nop);
        mbusy = 0;
        if (v < LO || v > HI) begin
            ms = ER; merr = 1; mdisp = 0; mentb = 0;
        end else if (ch != 0) begin
            ma = int'(v); mop = nop; mb = 0; mcb = 0;
            ms = EB; mdisp = ma; mentb = 1;
        end else begin
            mres = int'(v); ms = RS; mdone = 1; mdisp = mres; mentb = 0;
        end
    endtask

    task automatic m_exec(input int ch, input int nop);
        int x;
        x = (ms == RS) ? mres : ma;
        ma = x;
        if (mop == 0) m_finish(longint'(x) + mb, ch, nop);
        else if (mop == 1) m_finish(longint'(x) - mb, ch, nop);
        else begin
            if (mop == 2) mpend = longint'(x) * mb;
            else if (mb != 0) mpend = longint'(x) / mb;
            ms = EX; mbusy = 1; mcd = W; mfirst = 1;
            mchain = ch; mnext = nop;
        end
    endtask

    task automatic m_key(input int k);
        int cur, cnt, t, nop;
        if (k <= 9) begin
            if (ms == RS) begin
                ma = k; mca = (k != 0) ? 1 : 0; ms = EA; mdisp = k; mentb = 0;
            end else begin
                cur = (ms == EB) ? mb : ma;
                cnt = (ms == EB) ? mcb : mca;
                if (cnt < MD) begin
                    if (!(cur == 0 && k == 0)) cnt++;
                    cur = cur * 10 + ((cur < 0) ? -k : k);
                    if (ms == EB) begin mb = cur; mcb = cnt; end
                    else begin ma = cur; mca = cnt; end
                    mdisp = cur;
                end
            end
        end else if (k == 13) begin
            mtog = (mtog != 0) ? 0 : 1;
        end else if (k >= 10 && k <= 12) begin
            t = mtog;
            mtog = 0;
            if (k == 12 && t != 0) begin
                cur = (ms == RS) ? mres : ((ms == EB) ? mb : ma);
                if (longint'(cur) == LO) begin
                    ms = ER; merr = 1; mdisp = 0; mentb = 0;
                end else begin
                    if (ms == RS) mres = -cur;
                    else if (ms == EB) mb = -cur;
                    else ma = -cur;
                    mdisp = -cur;
                end
            end else if (!(k == 11 && t != 0)) begin
                nop = (k == 10) ? ((t != 0) ? 3 : 0) : ((k == 11) ? 1 : 2);
                if (ms == EB) begin
                    if (mcb == 0) mop = nop;
                    else m_exec(1, nop);
                end else begin
                    if (ms == RS) ma = mres;
                    mop = nop; mb = 0; mcb = 0; ms = EB; mentb = 1; mdisp = 0;
                end
            end
        end else if (k == 14) begin
            if (ms == EB || ms == RS) m_exec(0, 0);
        end
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_reset();
        end else begin
            mdone = 0;
            if (is_pressed_next && button == 4'hF) begin
                m_reset();
            end else if (ms == EX) begin
                if (mfirst != 0 && mop == 3 && mb == 0) begin
                    ms = ER; merr = 2; mdisp = 0; mbusy = 0; mentb = 0;
                end else begin
                    mcd--;
                    if (mcd == 0) m_finish(mpend, mchain, mnext);
                end
                mfirst = 0;
            end else if (ms != ER && is_pressed_next) begin
                m_key(int'(button));
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            cmp("display", longint'(display_value), mdisp);
            cmp("entering_b", longint'(entering_b), mentb);
            cmp("op_code", longint'(op_code), mop);
            cmp("toggle", longint'(toggle_active), mtog);
            cmp("busy", longint'(busy), mbusy);
            cmp("done", longint'(done), mdone);
            cmp("error", longint'(error), merr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] k);
        @(negedge clock);
        button = k;
        is_pressed_next = 1'b1;
        @(negedge clock);
        is_pressed_next = 1'b0;
        button = 4'd0;
    endtask

    task automatic run(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c >= "0" && c <= "9") press(4'(c - "0"));
            else press(4'(c - "A" + 10));
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles", n);
        end
    endtask

    int n;

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clock);
        cmp("rst_display", longint'(display_value), 0);
        cmp("rst_busy", longint'(busy), 0);
        cmp("rst_op", longint'(op_code), 0);
        cmp("rst_error", longint'(error), 0);
        reset = 1'b1;

        run("9A7E");
        cmp("add_done", longint'(done), 1);
        cmp("add_busy", longint'(busy), 0);
        cmp("add_val", longint'(display_value), 16);
        run("F");
        cmp("clr_val", longint'(display_value), 0);
        cmp("clr_entb", longint'(entering_b), 0);

        run("9D");
        cmp("tog_on", longint'(toggle_active), 1);
        run("C");
        cmp("neg_a", longint'(display_value), -9);
        cmp("tog_off", longint'(toggle_active), 0);
        run("C7E");
        wait_idle(n);
        cmp("mul_busy_cycles", n, 16);
        cmp("mul_neg", longint'(display_value), -63);

        run("F9DCC7DCE");
        wait_idle(n);
        cmp("mul_negneg", longint'(display_value), 63);

        run("F9DCDA7E");
        wait_idle(n);
        cmp("div_neg", longint'(display_value), -1);

        run("F9DA0E");
        wait_idle(n);
        cmp("div0_err", longint'(error), 2);
        cmp("div0_disp", longint'(display_value), 0);
        run("5");
        cmp("err_digit", longint'(display_value), 0);

        run("F2A3C");
        cmp("chain_mid", longint'(display_value), 5);
        run("4E");
        wait_idle(n);
        cmp("chain_fin", longint'(display_value), 20);
        run("E");
        wait_idle(n);
        cmp("repeat_eq", longint'(display_value), 80);

        run("F9B7DCE");
        wait_idle(n);
        cmp("sub_negb", longint'(display_value), 16);

        run("F12345");
        cmp("max_digits", longint'(display_value), 1234);
        run("C9E");
        wait_idle(n);
        cmp("mul_big", longint'(display_value), 11106);
        run("F9999C9E");
        wait_idle(n);
        cmp("mul_ovf", longint'(error), 1);

        run("F3C5E");
        run("7");
        wait_idle(n);
        cmp("busy_drop", longint'(display_value), 15);

        run("F3C5E");
        repeat (3) @(negedge clock);
        run("F");
        cmp("midclr_busy", longint'(busy), 0);
        cmp("midclr_disp", longint'(display_value), 0);
        cmp("midclr_entb", longint'(entering_b), 0);
        repeat (20) @(negedge clock);

        run("3C5E");
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        cmp("arst_busy", longint'(busy), 0);
        cmp("arst_op", longint'(op_code), 0);
        cmp("arst_entb", longint'(entering_b), 0);
        cmp("arst_disp", longint'(display_value), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run("6A1E");
        cmp("post_rst", longint'(display_value), 7);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
